// File: rtl/nibble_serial_adder_ctrl.sv
// Wide unsigned adder that reuses one 4-bit adder (no carry-in), one nibble per pass, LSB first.
// Optional macro CARRY_SKIP_EN: skip the carry-fixup pass when the incoming carry is 0.
module bit4_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*NIBBLES-1:0] SUM,
  output logic                 COUT
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_INC} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         tmp_q, tmp_d;
  logic               carry_q, carry_d, c1_q, c1_d, cout_q, cout_d, done_q, done_d;

  logic [3:0]         a_nib, b_nib, add_a, add_b, add_s;
  logic               add_co, last;
  logic [W-1:0]       sum_wr;

  bit4_adder u_add (.a(add_a), .b(add_b), .s(add_s), .cout(add_co));

  assign last = (idx_q == IDX_W'(NIBBLES - 1));

  // Operand nibble select and SUM with the current nibble replaced by the adder output.
  always_comb begin
    a_nib  = 4'h0;
    b_nib  = 4'h0;
    sum_wr = sum_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib            = a_q[4*i +: 4];
        b_nib            = b_q[4*i +: 4];
        sum_wr[4*i +: 4] = add_s;
      end
    end
  end

  always_comb begin
    add_a = a_nib;
    add_b = b_nib;
    if (state_q == S_INC) begin
      add_a = tmp_q;
      add_b = {3'b000, carry_q};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    tmp_d   = tmp_q;
    carry_d = carry_q;
    c1_d    = c1_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          idx_d   = '0;
          carry_d = 1'b0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
`ifdef CARRY_SKIP_EN
        if (!carry_q) begin
          sum_d   = sum_wr;
          carry_d = add_co;
          if (last) begin
            cout_d  = add_co;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          tmp_d   = add_s;
          c1_d    = add_co;
          state_d = S_INC;
        end
`else
        tmp_d   = add_s;
        c1_d    = add_co;
        state_d = S_INC;
`endif
      end
      S_INC: begin
        // Operand overflow and fixup overflow are mutually exclusive, so OR is exact.
        sum_d   = sum_wr;
        carry_d = c1_q | add_co;
        if (last) begin
          cout_d  = c1_q | add_co;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ADD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      tmp_q   <= '0;
      carry_q <= 1'b0;
      c1_q    <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      tmp_q   <= tmp_d;
      carry_q <= carry_d;
      c1_q    <= c1_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = (state_q != S_IDLE);
  assign DONE = done_q;
  assign SUM  = sum_q;
  assign COUT = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized bench for nibble_serial_adder_ctrl (NIBBLES=4) against a plain-arithmetic reference.
module tb_nibble_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         CLK = 1'b0;
  logic         RST, START;
  logic [W-1:0] A, B, SUM;
  logic         BUSY, DONE, COUT;

  int checks = 0;
  int errs   = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Latency from cycle 0 to DONE; K counts nibbles that receive a carry from below.
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int k = 0;
    logic [63:0] mask, lo;
    for (int i = 0; i < N; i++) begin
      mask = (64'd1 << (4 * i)) - 64'd1;
      lo   = ({48'd0, a} & mask) + ({48'd0, b} & mask);
      if (i > 0 && lo[4*i]) k++;
    end
`ifdef CARRY_SKIP_EN
    return N + k + 1;
`else
    return 2 * N + 1;
`endif
  endfunction

  // Called at #1 after an edge; that cycle is cycle 0. Returns at #1 in the DONE cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int junk_cyc);
    int lat, done_cyc;
    logic [W:0] ref_sum;
    ref_sum  = {1'b0, a} + {1'b0, b};
    lat      = exp_lat(a, b);
    done_cyc = -1;
    START = 1'b1; A = a; B = b;
    for (int cyc = 1; cyc <= 4 * N + 8 && done_cyc < 0; cyc++) begin
      @(posedge CLK); #1;
      if (cyc == 1) begin
        START = 1'b0; A = W'($urandom); B = W'($urandom);
      end
      if (junk_cyc > 1 && cyc == junk_cyc) begin
        START = 1'b1; A = 16'h1111; B = 16'h1111;
      end else if (junk_cyc > 1 && cyc == junk_cyc + 1) begin
        START = 1'b0;
      end
      if (DONE) done_cyc = cyc;
      else if (!BUSY) check("busy_during_op", {63'd0, BUSY}, 64'd1);
    end
    if (done_cyc < 0) check("done_timeout", 64'd0, 64'd1);
    else begin
      check("latency", done_cyc, lat);
      check("busy_at_done", {63'd0, BUSY}, 64'd0);
      check("sum", {48'd0, SUM}, {48'd0, ref_sum[W-1:0]});
      check("cout", {63'd0, COUT}, {63'd0, ref_sum[W]});
    end
  endtask

  task automatic idle_hold(input int n, input logic [W-1:0] es, input logic ec);
    START = 1'b0;
    repeat (n) begin
      @(posedge CLK); #1;
      check("done_single", {63'd0, DONE}, 64'd0);
      check("sum_hold", {48'd0, SUM}, {48'd0, es});
      check("cout_hold", {63'd0, COUT}, {63'd0, ec});
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   rs;
    int           jc, dones;
    RST = 1'b1; START = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", {63'd0, BUSY}, 64'd0);
    check("rst_done", {63'd0, DONE}, 64'd0);
    check("rst_sum", {48'd0, SUM}, 64'd0);
    check("rst_cout", {63'd0, COUT}, 64'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run_op(16'h1234, 16'h4321, 0);
    idle_hold(2, 16'h5555, 1'b0);
    run_op(16'hFFFF, 16'h0001, 0);
    idle_hold(2, 16'h0000, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 0);
    idle_hold(3, 16'hFFFE, 1'b1);

    // Ignored START mid-op, then back-to-back START in the DONE cycle.
    run_op(16'h000A, 16'h0006, 3);
    run_op(16'h0003, 16'h0004, 0);
    idle_hold(2, 16'h0007, 1'b0);

    // Reset in cycle 4 abandons the operation.
    START = 1'b1; A = 16'h1234; B = 16'h4321;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge CLK); #1;
      if (cyc == 1) START = 1'b0;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("midrst_busy", {63'd0, BUSY}, 64'd0);
    check("midrst_sum", {48'd0, SUM}, 64'd0);
    check("midrst_cout", {63'd0, COUT}, 64'd0);
    check("midrst_done", {63'd0, DONE}, 64'd0);
    dones = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (DONE) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_op(16'h0009, 16'h0002, 0);
    idle_hold(1, 16'h000B, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = ~ra + W'($urandom_range(0, 2));
      rs = {1'b0, ra} + {1'b0, rb};
      jc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, exp_lat(ra, rb) - 2)) : 0;
      run_op(ra, rb, jc);
      if ($urandom_range(0, 2) != 0) idle_hold(int'($urandom_range(1, 3)), rs[W-1:0], rs[W]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
